// File: rtl/ascon_phase_sequencer.sv
// ASCON phase sequencer: polices KEY/NONCE/AD/DATA/TAG beat order on a raw
// AXI-Stream and forwards legal beats unchanged toward the padder.
module ascon_phase_sequencer #(
   parameter int KEY_WORDS   = 2,
   parameter int NONCE_WORDS = 2,
   parameter int TAG_WORDS   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  mode_i,
   input  logic [63:0] s_axis_tdata_i,
   input  logic [7:0]  s_axis_tkeep_i,
   input  logic [2:0]  s_axis_tuser_i,
   input  logic        s_axis_tlast_i,
   input  logic        s_axis_tvalid_i,
   output logic        s_axis_tready_o,
   output logic [63:0] m_axis_tdata_o,
   output logic [7:0]  m_axis_tkeep_o,
   output logic [2:0]  m_axis_tuser_o,
   output logic        m_axis_tlast_o,
   output logic        m_axis_tvalid_o,
   input  logic        m_axis_tready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [2:0]  phase_o
);

   localparam logic [1:0] MODE_AEAD_ENC = 2'd0;
   localparam logic [1:0] MODE_AEAD_DEC = 2'd1;
   localparam logic [1:0] MODE_HASH     = 2'd2;

   localparam logic [2:0] TUSER_KEY   = 3'd0;
   localparam logic [2:0] TUSER_NONCE = 3'd1;
   localparam logic [2:0] TUSER_AD    = 3'd2;
   localparam logic [2:0] TUSER_PT    = 3'd3;
   localparam logic [2:0] TUSER_CT    = 3'd4;
   localparam logic [2:0] TUSER_MSG   = 3'd5;
   localparam logic [2:0] TUSER_TAG   = 3'd6;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_KEY        = 3'd1;
   localparam logic [2:0] S_NONCE      = 3'd2;
   localparam logic [2:0] S_AD_OR_DATA = 3'd3;
   localparam logic [2:0] S_DATA       = 3'd4;
   localparam logic [2:0] S_TAG        = 3'd5;
   localparam logic [2:0] S_DRAIN      = 3'd6;

   localparam logic [3:0] KEY_LAST   = 4'(KEY_WORDS - 1);
   localparam logic [3:0] NONCE_LAST = 4'(NONCE_WORDS - 1);
   localparam logic [3:0] TAG_LAST   = 4'(TAG_WORDS - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] mode_q, mode_d;
   logic       err_q, err_d;
   logic       done_q, done_d;

   logic [2:0] data_user;
   logic       is_ad;
   logic       is_data;
   logic       is_dec;
   logic       legal;
   logic       active;
   logic       bad_beat;
   logic       fwd_hs;
   logic       phase_end;
   logic [2:0] next_fwd;

   assign m_axis_tdata_o = s_axis_tdata_i;
   assign m_axis_tkeep_o = s_axis_tkeep_i;
   assign m_axis_tuser_o = s_axis_tuser_i;
   assign m_axis_tlast_o = s_axis_tlast_i;

   always_comb begin
      data_user = TUSER_MSG;
      unique case (mode_q)
         MODE_AEAD_ENC: data_user = TUSER_PT;
         MODE_AEAD_DEC: data_user = TUSER_CT;
         default:       data_user = TUSER_MSG;
      endcase
   end

   assign is_ad   = (s_axis_tuser_i == TUSER_AD);
   assign is_data = (s_axis_tuser_i == data_user);
   assign is_dec  = (mode_q == MODE_AEAD_DEC);

   // Fixed-length phases must assert tlast exactly on their final beat.
   always_comb begin
      legal = 1'b0;
      case (state_q)
         S_KEY:
            legal = (s_axis_tuser_i == TUSER_KEY) &&
                    (s_axis_tlast_i == (cnt_q == KEY_LAST));
         S_NONCE:
            legal = (s_axis_tuser_i == TUSER_NONCE) &&
                    (s_axis_tlast_i == (cnt_q == NONCE_LAST));
         S_AD_OR_DATA:
            legal = is_ad || is_data;
         S_DATA:
            legal = is_data;
         S_TAG:
            legal = (s_axis_tuser_i == TUSER_TAG) &&
                    (s_axis_tlast_i == (cnt_q == TAG_LAST));
         default:
            legal = 1'b0;
      endcase
   end

   assign active   = (state_q != S_IDLE) && (state_q != S_DRAIN);
   assign bad_beat = active && s_axis_tvalid_i && !legal;
   assign fwd_hs   = active && s_axis_tvalid_i && legal && m_axis_tready_i;

   // A data-type beat in AD_OR_DATA means the AD phase was empty.
   assign phase_end = s_axis_tlast_i ||
                      ((state_q == S_AD_OR_DATA) && !is_ad);

   always_comb begin
      next_fwd = state_q;
      case (state_q)
         S_KEY:   next_fwd = S_NONCE;
         S_NONCE: next_fwd = S_AD_OR_DATA;
         S_AD_OR_DATA: begin
            if (is_ad || !s_axis_tlast_i) begin
               next_fwd = S_DATA;
            end else begin
               next_fwd = is_dec ? S_TAG : S_IDLE;
            end
         end
         S_DATA:  next_fwd = is_dec ? S_TAG : S_IDLE;
         S_TAG:   next_fwd = S_IDLE;
         default: next_fwd = state_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               mode_d  = mode_i;
               err_d   = 1'b0;
               state_d = (mode_i == MODE_HASH) ? S_DATA : S_KEY;
            end
         end
         S_DRAIN: begin
            if (s_axis_tvalid_i && s_axis_tlast_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            if (bad_beat) begin
               err_d   = 1'b1;
               state_d = s_axis_tlast_i ? S_IDLE : S_DRAIN;
            end else if (fwd_hs) begin
               cnt_d = cnt_q + 4'd1;
               if (phase_end) begin
                  state_d = next_fwd;
               end
               done_d = phase_end && (next_fwd == S_IDLE);
            end
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         mode_q  <= MODE_HASH;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign s_axis_tready_o = (state_q == S_DRAIN) || bad_beat ||
                            (active && m_axis_tready_i);
   assign m_axis_tvalid_o = active && s_axis_tvalid_i && legal;
   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = done_q;
   assign err_o           = err_q;
   assign phase_o         = state_q;

endmodule

// File: tb/tb_ascon_phase_sequencer.sv
// Bench for ascon_phase_sequencer: phase-rule model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ascon_phase_sequencer;

   localparam logic [1:0] M_ENC  = 2'd0;
   localparam logic [1:0] M_DEC  = 2'd1;
   localparam logic [1:0] M_HASH = 2'd2;

   localparam logic [2:0] U_KEY   = 3'd0;
   localparam logic [2:0] U_NONCE = 3'd1;
   localparam logic [2:0] U_AD    = 3'd2;
   localparam logic [2:0] U_PT    = 3'd3;
   localparam logic [2:0] U_CT    = 3'd4;
   localparam logic [2:0] U_MSG   = 3'd5;
   localparam logic [2:0] U_TAG   = 3'd6;

   localparam int P_IDLE = 0, P_KEY = 1, P_NONCE = 2, P_ADD = 3;
   localparam int P_DATA = 4, P_TAG = 5, P_DRAIN = 6;
   localparam int KW = 2, NW = 2, TW = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = M_ENC;
   logic [63:0] sdata = 64'd0;
   logic [7:0]  skeep = 8'hFF;
   logic [2:0]  suser = U_KEY;
   logic        slast = 1'b0;
   logic        svalid = 1'b0;
   logic        mready = 1'b1;
   logic        s_tready;
   logic [63:0] m_data;
   logic [7:0]  m_keep;
   logic [2:0]  m_user;
   logic        m_last, m_tvalid;
   logic        busy, done, err;
   logic [2:0]  phase;

   ascon_phase_sequencer #(
      .KEY_WORDS(KW), .NONCE_WORDS(NW), .TAG_WORDS(TW)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
      .s_axis_tdata_i(sdata), .s_axis_tkeep_i(skeep),
      .s_axis_tuser_i(suser), .s_axis_tlast_i(slast),
      .s_axis_tvalid_i(svalid), .s_axis_tready_o(s_tready),
      .m_axis_tdata_o(m_data), .m_axis_tkeep_o(m_keep),
      .m_axis_tuser_o(m_user), .m_axis_tlast_o(m_last),
      .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(mready),
      .busy_o(busy), .done_o(done), .err_o(err), .phase_o(phase)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural model: phase, position in phase, mode, flags.
   int         mph = P_IDLE;
   int         mcnt = 0;
   logic [1:0] mmode = M_HASH;
   logic       merr = 1'b0;
   logic       mdone = 1'b0;

   function automatic logic [2:0] data_type(logic [1:0] md);
      if (md == M_ENC) return U_PT;
      if (md == M_DEC) return U_CT;
      return U_MSG;
   endfunction

   function automatic bit legal(int ph, logic [1:0] md, int cnt,
                                logic [2:0] u, logic l);
      case (ph)
         P_KEY:   return (u == U_KEY) && (l == (cnt == KW - 1));
         P_NONCE: return (u == U_NONCE) && (l == (cnt == NW - 1));
         P_TAG:   return (u == U_TAG) && (l == (cnt == TW - 1));
         P_ADD:   return (u == U_AD) || (u == data_type(md));
         P_DATA:  return u == data_type(md);
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit is_active(int ph);
      return ph >= P_KEY && ph <= P_TAG;
   endfunction

   task automatic model_step();
      bit act, ok, bad, fwd;
      int nxt;
      act = is_active(mph);
      ok  = legal(mph, mmode, mcnt, suser, slast);
      bad = act && svalid && !ok;
      fwd = act && svalid && ok && mready;
      mdone = 1'b0;
      nxt = mph;
      if (mph == P_IDLE) begin
         if (start) begin
            mmode = mode;
            merr  = 1'b0;
            mcnt  = 0;
            mph   = (mode == M_HASH) ? P_DATA : P_KEY;
         end
      end else if (mph == P_DRAIN) begin
         if (svalid && slast) mph = P_IDLE;
      end else if (bad) begin
         merr = 1'b1;
         mcnt = 0;
         mph  = slast ? P_IDLE : P_DRAIN;
      end else if (fwd) begin
         if (mph == P_ADD && suser != U_AD && !slast) nxt = P_DATA;
         else if (slast) begin
            case (mph)
               P_KEY:   nxt = P_NONCE;
               P_NONCE: nxt = P_ADD;
               P_ADD:   nxt = (suser == U_AD) ? P_DATA :
                              (mmode == M_DEC) ? P_TAG : P_IDLE;
               P_DATA:  nxt = (mmode == M_DEC) ? P_TAG : P_IDLE;
               default: nxt = P_IDLE;
            endcase
         end
         mdone = (nxt == P_IDLE);
         mcnt  = (nxt != mph) ? 0 : (mcnt + 1) % 16;
         mph   = nxt;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mph = P_IDLE; mcnt = 0; mmode = M_HASH;
         merr = 1'b0; mdone = 1'b0;
      end else begin
         model_step();
      end
   end

   // Per-cycle compare against the model, plus logging for scenarios.
   logic [63:0] fwd_q[$];
   int          ph_log[$];
   bit          log_en = 1'b0;
   int          ndone = 0;

   always @(negedge clk) begin
      bit act, ok, e_rdy, e_vld;
      act   = is_active(mph);
      ok    = legal(mph, mmode, mcnt, suser, slast);
      e_vld = act && svalid && ok;
      e_rdy = (mph == P_DRAIN) || (act && svalid && !ok) ||
              (act && mready);
      chk("phase", 64'(phase), 64'(mph));
      chk("busy", 64'(busy), 64'(mph != P_IDLE));
      chk("err", 64'(err), 64'(merr));
      chk("done", 64'(done), 64'(mdone));
      chk("s_tready", 64'(s_tready), 64'(e_rdy));
      chk("m_tvalid", 64'(m_tvalid), 64'(e_vld));
      chk("m_data", m_data, sdata);
      chk("m_sideband", {51'd0, m_keep, m_user, m_last},
          {51'd0, skeep, suser, slast});
      if (m_tvalid && mready) fwd_q.push_back(m_data);
      if (done) ndone++;
      if (log_en && (ph_log.size() == 0 || int'(phase) != ph_log[$]))
         ph_log.push_back(int'(phase));
   end

   bit tog = 1'b0;
   always @(posedge clk) begin
      #1;
      if (tog) mready = ~mready;
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(logic [1:0] m);
      mode = m;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic beat(logic [2:0] u, logic l, logic [63:0] d);
      bit ok;
      ok = 1'b0;
      sdata = d; suser = u; slast = l; svalid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
      svalid = 1'b0;
      slast = 1'b0;
   endtask

   task automatic chk_fwd(string nm, logic [63:0] exp[$]);
      chk({nm, "_count"}, 64'(fwd_q.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < fwd_q.size(); i++)
         chk(nm, fwd_q[i], exp[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_q[$];
      int          exp_ph[$];

      #2 rst = 1'b0;
      cyc(2);
      svalid = 1'b1; suser = U_KEY;
      #1;
      chk("rst_phase", 64'(phase), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      svalid = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(2);
      chk("idle_tready", 64'(s_tready), 64'd0);

      // ENC with AD, plus an ignored start during KEY
      fwd_q.delete(); ndone = 0;
      do_start(M_ENC);
      beat(U_KEY, 1'b0, 64'h11);
      do_start(M_HASH);
      chk("start_ignored_phase", 64'(phase), 64'd1);
      beat(U_KEY, 1'b1, 64'h12);
      beat(U_NONCE, 1'b0, 64'h21);
      beat(U_NONCE, 1'b1, 64'h22);
      beat(U_AD, 1'b1, 64'h31);
      chk("enc_in_data", 64'(phase), 64'd4);
      beat(U_PT, 1'b0, 64'h41);
      beat(U_PT, 1'b0, 64'h42);
      beat(U_PT, 1'b1, 64'h43);
      cyc(3);
      exp_q = '{64'h11, 64'h12, 64'h21, 64'h22,
                64'h31, 64'h41, 64'h42, 64'h43};
      chk_fwd("enc_fwd", exp_q);
      chk("enc_done_cnt", 64'(ndone), 64'd1);
      chk("enc_err", 64'(err), 64'd0);

      // DEC with empty AD
      fwd_q.delete(); ndone = 0; ph_log.delete(); log_en = 1'b1;
      cyc(1);
      do_start(M_DEC);
      beat(U_KEY, 1'b0, 64'hA1);
      beat(U_KEY, 1'b1, 64'hA2);
      beat(U_NONCE, 1'b0, 64'hB1);
      beat(U_NONCE, 1'b1, 64'hB2);
      beat(U_CT, 1'b1, 64'hC1);
      beat(U_TAG, 1'b0, 64'hD1);
      beat(U_TAG, 1'b1, 64'hD2);
      cyc(2);
      log_en = 1'b0;
      exp_ph = '{0, 1, 2, 3, 5, 0};
      chk("dec_phase_count", 64'(ph_log.size()), 64'(exp_ph.size()));
      for (int i = 0; i < exp_ph.size() && i < ph_log.size(); i++)
         chk("dec_phase_seq", 64'(ph_log[i]), 64'(exp_ph[i]));
      chk("dec_done_cnt", 64'(ndone), 64'd1);
      chk("dec_err", 64'(err), 64'd0);

      // ENC with empty AD: first PT beat without tlast goes to DATA
      fwd_q.delete(); ndone = 0;
      do_start(M_ENC);
      beat(U_KEY, 1'b0, 64'h1); beat(U_KEY, 1'b1, 64'h2);
      beat(U_NONCE, 1'b0, 64'h3); beat(U_NONCE, 1'b1, 64'h4);
      beat(U_PT, 1'b0, 64'h5);
      chk("skip_ad_phase", 64'(phase), 64'd4);
      beat(U_PT, 1'b1, 64'h6);
      cyc(2);
      chk("skip_ad_done", 64'(ndone), 64'd1);

      // HASH with a toggling downstream ready
      fwd_q.delete(); ndone = 0;
      do_start(M_HASH);
      tog = 1'b1;
      beat(U_MSG, 1'b0, 64'hE1);
      beat(U_MSG, 1'b0, 64'hE2);
      beat(U_MSG, 1'b0, 64'hE3);
      beat(U_MSG, 1'b1, 64'hE4);
      tog = 1'b0;
      cyc(2);
      mready = 1'b1;
      cyc(1);
      exp_q = '{64'hE1, 64'hE2, 64'hE3, 64'hE4};
      chk_fwd("hash_fwd", exp_q);
      chk("hash_done_cnt", 64'(ndone), 64'd1);

      // KEY with tlast on its first beat
      fwd_q.delete(); ndone = 0;
      do_start(M_ENC);
      beat(U_KEY, 1'b1, 64'hBAD);
      cyc(1);
      chk("keylast_err", 64'(err), 64'd1);
      chk("keylast_phase", 64'(phase), 64'd0);
      chk("keylast_fwd", 64'(fwd_q.size()), 64'd0);
      chk("keylast_done", 64'(ndone), 64'd0);
      do_start(M_HASH);
      chk("restart_clears_err", 64'(err), 64'd0);
      beat(U_MSG, 1'b1, 64'h51);
      cyc(2);
      chk("restart_done", 64'(ndone), 64'd1);

      // NONCE slot carrying an AD beat drains to the next tlast
      fwd_q.delete(); ndone = 0;
      do_start(M_ENC);
      beat(U_KEY, 1'b0, 64'h61);
      beat(U_KEY, 1'b1, 64'h62);
      beat(U_AD, 1'b0, 64'h70);
      chk("drain_phase", 64'(phase), 64'd6);
      chk("drain_err", 64'(err), 64'd1);
      sdata = 64'h71; suser = U_MSG; slast = 1'b0; svalid = 1'b1;
      @(negedge clk);
      chk("drain_tready", 64'(s_tready), 64'd1);
      chk("drain_tvalid", 64'(m_tvalid), 64'd0);
      @(posedge clk);
      #1;
      beat(U_MSG, 1'b1, 64'h72);
      cyc(2);
      chk("drain_to_idle", 64'(phase), 64'd0);
      chk("drain_done", 64'(ndone), 64'd0);
      exp_q = '{64'h61, 64'h62};
      chk_fwd("drain_fwd", exp_q);

      // Reset in the middle of a HASH data phase
      fwd_q.delete(); ndone = 0;
      do_start(M_HASH);
      beat(U_MSG, 1'b0, 64'h81);
      sdata = 64'h82; suser = U_MSG; svalid = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("midrst_phase", 64'(phase), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_tready", 64'(s_tready), 64'd0);
      chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
      svalid = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      fwd_q.delete();
      do_start(M_HASH);
      beat(U_MSG, 1'b0, 64'h91);
      beat(U_MSG, 1'b1, 64'h92);
      cyc(2);
      exp_q = '{64'h91, 64'h92};
      chk_fwd("post_rst_fwd", exp_q);
      chk("post_rst_done", 64'(ndone), 64'd1);
      chk("post_rst_err", 64'(err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ascon_phase_sequencer.md
ASCON_PHASE_SEQUENCER -- requirements
Module: ascon_phase_sequencer

Interface
REQ-001 The block SHALL have parameter KEY_WORDS, default 2: exact beat count of a TUSER_KEY phase (legal 1..15).
REQ-002 The block SHALL have parameter NONCE_WORDS, default 2: exact beat count of a TUSER_NONCE phase (legal 1..15).
REQ-003 The block SHALL have parameter TAG_WORDS, default 2: exact beat count of a TUSER_TAG phase (legal 1..15).
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start_i, input, 1: one-cycle request to begin an operation; mode_i sampled with it.
REQ-007 The block SHALL have port mode_i, input, ascon_mode_t: MODE_AEAD_ENC, MODE_AEAD_DEC or MODE_HASH.
REQ-008 The block SHALL have ports s_axis_tdata_i (ascon_word_t), s_axis_tkeep_i (8), s_axis_tuser_i (axi_tuser_t), s_axis_tlast_i (1), s_axis_tvalid_i (1) as inputs, s_axis_tready_o (1) as output: raw upstream stream.
REQ-009 The block SHALL have ports m_axis_tdata_o, m_axis_tkeep_o, m_axis_tuser_o, m_axis_tlast_o, m_axis_tvalid_o as outputs, m_axis_tready_i as input, same widths: stream toward the padder.
REQ-010 The block SHALL have outputs busy_o (1), done_o (1), err_o (1), phase_o (3): status.

Function
REQ-011 States SHALL be IDLE, KEY, NONCE, AD_OR_DATA, DATA, TAG, DRAIN; phase_o SHALL encode them 0..6 in that order.
REQ-012 In IDLE, start_i=1 SHALL latch mode_i and go to KEY (AEAD modes) or DATA (MODE_HASH); start_i outside IDLE SHALL be ignored.
REQ-013 Data path SHALL be zero-latency combinational: m_axis_t{data,keep,user,last}_o = s_axis_* inputs.
REQ-014 Legal beat: tuser equals the state's expected type and tlast equals (beat counter == phase length-1) for fixed-length phases; any tlast allowed in AD/DATA phases.
REQ-015 Expected tuser: KEY->TUSER_KEY; NONCE->TUSER_NONCE; AD_OR_DATA->TUSER_AD or the data type; DATA->TUSER_PT (ENC), TUSER_CT (DEC), TUSER_MSG (HASH); TAG->TUSER_TAG.
REQ-016 In KEY/NONCE/AD_OR_DATA/DATA/TAG with a legal beat: m_axis_tvalid_o=s_axis_tvalid_i, s_axis_tready_o=m_axis_tready_i.
REQ-017 With an illegal beat: m_axis_tvalid_o=0, s_axis_tready_o=1, beat discarded, err_o set; next state DRAIN, or IDLE if that beat has tlast=1.
REQ-018 Beat counter (4 bits) SHALL increment on each forwarded handshake and clear on every phase transition.
REQ-019 Transitions on forwarded tlast handshake: KEY->NONCE; NONCE->AD_OR_DATA; AD_OR_DATA with TUSER_AD->DATA; AD_OR_DATA with data type->TAG (DEC) or IDLE (ENC); DATA->TAG (DEC) or IDLE (ENC, HASH); TAG->IDLE.
REQ-020 AD_OR_DATA with data-type beat and tlast=0 SHALL move to DATA (AD phase skipped, empty AD).
REQ-021 done_o SHALL pulse one cycle, registered, the cycle after the final forwarded handshake returning to IDLE without error.
REQ-022 DRAIN: s_axis_tready_o=1, m_axis_tvalid_o=0; beats discarded; tlast=1 handshake -> IDLE, no done_o.
REQ-023 IDLE: s_axis_tready_o=0, m_axis_tvalid_o=0.
REQ-024 err_o SHALL be sticky, cleared only by reset or an accepted start_i.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 Stalls (m_axis_tready_i=0) SHALL hold state and counter; no beat dropped or duplicated.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, counter 0, latched mode MODE_HASH, done_o=0, err_o=0, busy_o=0, phase_o=0, hence s_axis_tready_o=0, m_axis_tvalid_o=0.
REQ-028 Reset mid-operation SHALL abandon the operation with no done_o; first start_i after release behaves as from power-up.

Verification
REQ-029 ENC: start, KEY x2, NONCE x2, AD x1(tlast), PT x3(tlast last) -> all 8 beats forwarded unchanged, done_o pulse once, err_o=0.
REQ-030 DEC empty AD: KEY x2, NONCE x2, CT x1(tlast), TAG x2 -> phase 0,1,2,3,5,0 sequence, done_o pulse, err_o=0.
REQ-031 HASH with m_axis_tready_i toggling 1/0 each cycle, MSG x4 -> 4 forwarded beats in order, done_o once.
REQ-032 KEY with tlast on beat 1 of 2 -> beat dropped, err_o=1, state IDLE, no done_o; next start_i clears err_o.
REQ-033 NONCE beat with TUSER_AD, tlast=0 -> DRAIN; 2 further beats absorbed with tready=1, m_tvalid=0; IDLE after tlast beat.
REQ-034 rst asserted during DATA -> outputs at reset values same cycle; restarted HASH op completes normally.
